// File: rtl/rv32i_single_cycle_core.sv
// Single-cycle RV32I-subset core: fetch, decode, execute, memory access and writeback in one clock.
// Instruction and data memories are word arrays in the named blocks IM and DM.
module rv32i_single_cycle_core #(
  parameter int unsigned IMEM_DEPTH = 1024,
  parameter int unsigned DMEM_DEPTH = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input logic clk,
  input logic rst
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned IAW  = $clog2(IMEM_DEPTH);
  localparam int unsigned DAW  = $clog2(DMEM_DEPTH);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] instruction;
  logic [XLEN-1:0] Alu_out;
  logic [XLEN-1:0] result;
  logic            RF_WE;
  logic            DM_WE;

  logic [XLEN-1:0] r_rf [0:NREG-1];

  logic [6:0]      w_opcode;
  logic [4:0]      w_rd;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [2:0]      w_funct3;
  logic            w_funct7b5;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic [XLEN-1:0] w_alu_b;
  logic [2:0]      w_alu_f3;
  logic            w_alu_alt;
  logic            w_br_taken;
  logic [XLEN-1:0] w_dm_rdata;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_pc_next;
  logic            w_im_we;
  logic [IAW-1:0]  w_im_waddr;
  logic [XLEN-1:0] w_im_wdata;

  // Instruction-memory write port is reserved for a program loader and tied off here.
  assign w_im_we    = 1'b0;
  assign w_im_waddr = '0;
  assign w_im_wdata = '0;

  if (IMEM_DEPTH > 0) begin : IM
    logic [XLEN-1:0] mem [0:IMEM_DEPTH-1];
    always_ff @(posedge clk) begin
      if (w_im_we) mem[w_im_waddr] <= w_im_wdata;
    end
    assign instruction = mem[PC[IAW+1:2]];
  end

  assign w_opcode   = instruction[6:0];
  assign w_rd       = instruction[11:7];
  assign w_funct3   = instruction[14:12];
  assign w_rs1      = instruction[19:15];
  assign w_rs2      = instruction[24:20];
  assign w_funct7b5 = instruction[30];

  assign w_imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign w_imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign w_imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
  assign w_imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};
  assign w_imm_u = {instruction[31:12], 12'h000};

  assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : r_rf[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : r_rf[w_rs2];

  // Decode: enables and ALU control; unknown opcodes fall through as a NOP.
  always_comb begin
    RF_WE     = 1'b0;
    DM_WE     = 1'b0;
    w_alu_f3  = 3'b000;
    w_alu_alt = 1'b0;
    w_alu_b   = w_rs2_val;
    case (w_opcode)
      OP_R: begin
        RF_WE     = 1'b1;
        w_alu_f3  = w_funct3;
        w_alu_alt = w_funct7b5;
      end
      OP_I: begin
        RF_WE     = 1'b1;
        w_alu_f3  = w_funct3;
        w_alu_alt = (w_funct3 == 3'b101) & w_funct7b5;
        w_alu_b   = w_imm_i;
      end
      OP_LW: begin
        RF_WE   = 1'b1;
        w_alu_b = w_imm_i;
      end
      OP_SW: begin
        DM_WE   = 1'b1;
        w_alu_b = w_imm_s;
      end
      OP_BR:          w_alu_alt = 1'b1;
      OP_JAL, OP_LUI: RF_WE     = 1'b1;
      default: ;
    endcase
    if (rst) begin
      RF_WE = 1'b0;
      DM_WE = 1'b0;
    end
  end

  // alt selects sub for funct3=000 and arithmetic shift for funct3=101.
  always_comb begin
    case (w_alu_f3)
      3'b000:  Alu_out = w_alu_alt ? (w_rs1_val - w_alu_b) : (w_rs1_val + w_alu_b);
      3'b001:  Alu_out = w_rs1_val << w_alu_b[4:0];
      3'b010:  Alu_out = {31'b0, $signed(w_rs1_val) < $signed(w_alu_b)};
      3'b011:  Alu_out = {31'b0, w_rs1_val < w_alu_b};
      3'b100:  Alu_out = w_rs1_val ^ w_alu_b;
      3'b101:  Alu_out = w_alu_alt ? $unsigned($signed(w_rs1_val) >>> w_alu_b[4:0])
                                   : (w_rs1_val >> w_alu_b[4:0]);
      3'b110:  Alu_out = w_rs1_val | w_alu_b;
      default: Alu_out = w_rs1_val & w_alu_b;
    endcase
  end

  assign w_br_taken = (w_opcode == OP_BR) &&
                      (((w_funct3 == 3'b000) && (w_rs1_val == w_rs2_val)) ||
                       ((w_funct3 == 3'b001) && (w_rs1_val != w_rs2_val)));

  if (DMEM_DEPTH > 0) begin : DM
    logic [XLEN-1:0] mem [0:DMEM_DEPTH-1];
    always_ff @(posedge clk) begin
      if (DM_WE) mem[Alu_out[DAW+1:2]] <= w_rs2_val;
    end
    assign w_dm_rdata = mem[Alu_out[DAW+1:2]];
  end

  assign w_pc_plus4 = PC + 32'd4;

  always_comb begin
    result = Alu_out;
    case (w_opcode)
      OP_LW:   result = w_dm_rdata;
      OP_JAL:  result = w_pc_plus4;
      OP_LUI:  result = w_imm_u;
      default: ;
    endcase
  end

  always_comb begin
    w_pc_next = w_pc_plus4;
    if (w_br_taken)                w_pc_next = PC + w_imm_b;
    else if (w_opcode == OP_JAL)   w_pc_next = PC + w_imm_j;
  end

  always_ff @(posedge clk) begin
    if (rst) PC <= RESET_PC;
    else     PC <= w_pc_next;
  end

  // Register file: x0 is never written, reads of x0 are forced to zero above.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (RF_WE && (w_rd != 5'd0)) begin
      r_rf[w_rd] <= result;
    end
  end

endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// Directed and randomized program bench for rv32i_single_cycle_core against an instruction-level model.
module tb_rv32i_single_cycle_core;
  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned N_RAND  = 4000;
  localparam logic [31:0] NOP     = 32'h00000013;
  localparam logic [6:0]  OP_I    = 7'b0010011;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rv32i_single_cycle_core #(
    .IMEM_DEPTH(DEPTH),
    .DMEM_DEPTH(DEPTH),
    .RESET_PC  (32'h0)
  ) dut (
    .clk(clk),
    .rst(rst)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] m_pc;
  logic [31:0] m_rf [32];
  logic [31:0] m_dm [DEPTH];
  logic [31:0] m_im [DEPTH];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic put_im(input int idx, input logic [31:0] w);
    m_im[idx]        = w;
    dut.IM.mem[idx]  = w;
  endtask

  task automatic fill_im_nop();
    for (int i = 0; i < DEPTH; i++) put_im(i, NOP);
  endtask

  task automatic check_regs(input string tag);
    for (int r = 0; r < 32; r++)
      check_eq($sformatf("%s_x%0d", tag, r), dut.r_rf[r], m_rf[r]);
  endtask

  // Holds reset across the given number of edges; leaves the bench just after a falling edge.
  task automatic apply_reset(input int unsigned edges);
    rst = 1'b1;
    for (int k = 0; k < int'(edges); k++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("rst_pc", dut.PC, 32'h0);
      check_eq("rst_rf_we", {31'b0, dut.RF_WE}, 32'h0);
      check_eq("rst_dm_we", {31'b0, dut.DM_WE}, 32'h0);
    end
    m_pc = 32'h0;
    for (int r = 0; r < 32; r++) m_rf[r] = 32'h0;
    check_regs("rst");
    rst = 1'b0;
    #1;
  endtask

  // One retired instruction: compare the DUT's view of it, then advance the model and the clock.
  task automatic step();
    logic [31:0] ins, a, b, imm_i, imm_s, imm_b, imm_j, res, npc, addr;
    logic        rfwe, dmwe;
    ins   = m_im[m_pc[11:2]];
    a     = m_rf[ins[19:15]];
    b     = m_rf[ins[24:20]];
    imm_i = 32'($signed(ins[31:20]));
    imm_s = 32'($signed({ins[31:25], ins[11:7]}));
    imm_b = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    imm_j = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    rfwe  = 1'b0;
    dmwe  = 1'b0;
    res   = 32'h0;
    addr  = 32'h0;
    npc   = m_pc + 32'd4;
    case (ins[6:0])
      7'b0110011: begin rfwe = 1'b1; res = ref_alu(ins[14:12], ins[30], a, b); end
      7'b0010011: begin
        rfwe = 1'b1;
        res  = ref_alu(ins[14:12], (ins[14:12] == 3'd5) && ins[30], a, imm_i);
      end
      7'b0000011: begin rfwe = 1'b1; addr = a + imm_i; res = m_dm[addr[11:2]]; end
      7'b0100011: begin dmwe = 1'b1; addr = a + imm_s; end
      7'b1100011: begin
        if ((ins[14:12] == 3'd0 && a == b) || (ins[14:12] == 3'd1 && a != b)) npc = m_pc + imm_b;
      end
      7'b1101111: begin rfwe = 1'b1; res = m_pc + 32'd4; npc = m_pc + imm_j; end
      7'b0110111: begin rfwe = 1'b1; res = {ins[31:12], 12'h000}; end
      default: ;
    endcase
    check_eq("pc", dut.PC, m_pc);
    check_eq("instruction", dut.instruction, ins);
    check_eq("rf_we", {31'b0, dut.RF_WE}, {31'b0, rfwe});
    check_eq("dm_we", {31'b0, dut.DM_WE}, {31'b0, dmwe});
    if (rfwe) check_eq("result", dut.result, res);
    if (dmwe) m_dm[addr[11:2]] = b;
    if (rfwe && ins[11:7] != 5'd0) m_rf[ins[11:7]] = res;
    m_pc = npc;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] gen_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [6:0]  bad_ops [5];
    bad_ops = '{7'h00, 7'h17, 7'h67, 7'h7f, 7'h0f};
    rd  = 5'($urandom_range(0, 31));
    rs1 = 5'($urandom_range(0, 31));
    rs2 = 5'($urandom_range(0, 31));
    f3  = 3'($urandom_range(0, 7));
    imm = 12'($urandom);
    case ($urandom_range(0, 9))
      0, 1: return enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                         rs2, rs1, f3, rd);
      2, 3: begin
        if (f3 == 3'd1) imm[11:5] = 7'h00;
        if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return enc_i(imm, rs1, f3, rd, OP_I);
      end
      4: return enc_i(imm, rs1, 3'b010, rd, 7'b0000011);
      5: return enc_s(imm, rs2, rs1);
      6: begin
        f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
        return enc_b(13'(4 * $urandom_range(1, 16)), rs2, rs1, f3);
      end
      7: return enc_j(21'(4 * $urandom_range(1, 16)), rd);
      8: return enc_u(20'($urandom), rd);
      default: return {25'($urandom), bad_ops[$urandom_range(0, 4)]};
    endcase
  endfunction

  initial begin
    logic [31:0] w;
    for (int i = 0; i < DEPTH; i++) begin
      m_dm[i]         = 32'h0;
      dut.DM.mem[i]   = 32'h0;
    end

    // Straight-line program with store and load.
    fill_im_nop();
    put_im(0, 32'h00500093);
    put_im(1, 32'h00A00113);
    put_im(2, 32'h002081B3);
    put_im(3, 32'h00302023);
    put_im(4, 32'h00002283);
    apply_reset(2);
    check_eq("a_alu_out", dut.Alu_out, 32'd5);
    check_eq("a_rf_we", {31'b0, dut.RF_WE}, 32'd1);
    step();
    step();
    check_eq("a_add_result", dut.result, 32'h0000000F);
    step();
    check_eq("a_x1", dut.r_rf[1], 32'd5);
    check_eq("a_x2", dut.r_rf[2], 32'd10);
    check_eq("a_x3", dut.r_rf[3], 32'd15);
    check_eq("a_sw_dm_we", {31'b0, dut.DM_WE}, 32'd1);
    check_eq("a_sw_rf_we", {31'b0, dut.RF_WE}, 32'd0);
    step();
    check_eq("a_dm0", dut.DM.mem[0], 32'd15);
    check_eq("a_lw_result", dut.result, 32'd15);
    step();
    check_eq("a_x5", dut.r_rf[5], 32'd15);
    for (int k = 0; k < 3; k++) step();
    check_eq("a_pc_after_nops", dut.PC, 32'h20);
    check_eq("a_dm0_kept", dut.DM.mem[0], 32'd15);
    check_regs("a");

    // Reset in the middle of the same program.
    apply_reset(1);
    for (int k = 0; k < 3; k++) step();
    apply_reset(1);
    check_eq("mid_dm0_retained", dut.DM.mem[0], 32'd15);
    step();
    check_eq("mid_restart_x1", dut.r_rf[1], 32'd5);

    // Taken and not-taken beq.
    fill_im_nop();
    put_im(0, 32'h00500093);
    put_im(1, 32'h00500113);
    put_im(2, enc_b(13'd8, 5'd2, 5'd1, 3'd0));
    apply_reset(1);
    step();
    step();
    check_eq("br_rf_we", {31'b0, dut.RF_WE}, 32'd0);
    step();
    check_eq("br_taken_pc", dut.PC, 32'h10);
    put_im(1, 32'h00600113);
    apply_reset(1);
    for (int k = 0; k < 3; k++) step();
    check_eq("br_not_taken_pc", dut.PC, 32'h0C);

    // ALU corner cases.
    fill_im_nop();
    put_im(0, enc_i(12'd1, 5'd0, 3'd0, 5'd1, OP_I));
    put_im(1, enc_r(7'h20, 5'd1, 5'd0, 3'd0, 5'd3));
    put_im(2, enc_r(7'h00, 5'd1, 5'd3, 3'd2, 5'd4));
    put_im(3, enc_r(7'h00, 5'd1, 5'd3, 3'd3, 5'd5));
    put_im(4, enc_u(20'h80000, 5'd6));
    put_im(5, enc_i({7'h20, 5'd4}, 5'd6, 3'd5, 5'd7, OP_I));
    put_im(6, enc_i(12'd7, 5'd0, 3'd0, 5'd0, OP_I));
    put_im(7, enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd8));
    apply_reset(1);
    for (int k = 0; k < 7; k++) step();
    check_eq("x0_read_zero", dut.result, 32'h0);
    step();
    check_eq("sub_0_minus_1", dut.r_rf[3], 32'hFFFFFFFF);
    check_eq("slt_neg1_1", dut.r_rf[4], 32'd1);
    check_eq("sltu_max_1", dut.r_rf[5], 32'd0);
    check_eq("srai_8000_4", dut.r_rf[7], 32'hF8000000);
    check_eq("x0_stored", dut.r_rf[0], 32'h0);

    // Random programs over the whole instruction memory with random data memory.
    for (int i = 0; i < DEPTH; i++) begin
      put_im(i, gen_instr());
      w             = $urandom;
      m_dm[i]       = w;
      dut.DM.mem[i] = w;
    end
    apply_reset(1);
    for (int n = 0; n < N_RAND; n++) begin
      step();
      if (n % 500 == 499) check_regs("rand");
    end
    check_regs("final");
    for (int i = 0; i < DEPTH; i++) check_eq($sformatf("dm%0d", i), dut.DM.mem[i], m_dm[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
